// File: rtl/serial_addsub_ctrl_if.sv
// rtl/serial_addsub_ctrl_if.sv - operand/result handshake bundle for the bit-serial add/sub controller
interface serial_addsub_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic             sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             carry_out;
  logic             overflow;

  // Upstream issuer drives operands and observes status/results
  modport master (
    output start, sub, a, b,
    input  busy, done, result, carry_out, overflow
  );

  // Controller consumes operands and produces status/results
  modport slave (
    input  start, sub, a, b,
    output busy, done, result, carry_out, overflow
  );
endinterface

// File: rtl/serial_addsub_ctrl.sv
// rtl/serial_addsub_ctrl.sv - bit-serial LSB-first adder/subtractor with start/busy/done handshake
module serial_addsub_ctrl #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input logic                 clk,
  input logic                 rst,
  serial_addsub_ctrl_if.slave bus
);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_RUN  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  logic [1:0]       state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] res_q;
  logic [CNT_W-1:0] count;
  logic             c_q;
  logic             cin_msb;
  logic             cout_q;
  logic             s;
  logic             cnext;

  // The single shared full-adder cell working on the current LSBs
  always_comb begin
    s     = a_sr[0] ^ b_sr[0] ^ c_q;
    cnext = (a_sr[0] & b_sr[0]) | (a_sr[0] & c_q) | (b_sr[0] & c_q);
  end

  // Sequencer: capture operands, shift WIDTH bits through the cell, latch flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      a_sr    <= '0;
      b_sr    <= '0;
      res_q   <= '0;
      count   <= '0;
      c_q     <= 1'b0;
      cin_msb <= 1'b0;
      cout_q  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            // Subtraction is A + ~B + 1: invert B and seed the carry with 1
            a_sr    <= bus.a;
            b_sr    <= bus.sub ? ~bus.b : bus.b;
            c_q     <= bus.sub;
            count   <= '0;
            res_q   <= '0;
            cin_msb <= 1'b0;
            cout_q  <= 1'b0;
            state   <= S_LOAD;
          end
        end
        S_LOAD: begin
          res_q <= '0;
          state <= S_RUN;
        end
        S_RUN: begin
          res_q <= {s, res_q[WIDTH-1:1]};
          a_sr  <= a_sr >> 1;
          b_sr  <= b_sr >> 1;
          c_q   <= cnext;
          count <= count + 1'b1;
          if (count == LAST_BIT) begin
            // Flags are captured on the final bit so they are valid during DONE
            cin_msb <= c_q;
            cout_q  <= cnext;
            state   <= S_DONE;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // Status and results; flags stay zero until the MSB edge sets them
  always_comb begin
    bus.busy      = (state != S_IDLE);
    bus.done      = (state == S_DONE);
    bus.result    = res_q;
    bus.carry_out = cout_q;
    bus.overflow  = cin_msb ^ cout_q;
  end
endmodule
